// File: rtl/ysyx_23060025_mem_rsp_pkg.sv
// ysyx_23060025_mem_rsp_pkg: responder state encoding and response codes shared by the memory responders.
package ysyx_23060025_mem_rsp_pkg;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DATA = 2'd2} state_e;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

// File: rtl/ysyx_23060025_mem_array.sv
// ysyx_23060025_mem_array: word store with a synchronous write port, a combinational read port and a range flag.
module ysyx_23060025_mem_array #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          MEM_WORDS = 1024
) (
    input  logic        clock,
    input  logic        we,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    input  logic [31:0] raddr,
    output logic [31:0] rdata,
    output logic        rok
);
    localparam int AW = $clog2(MEM_WORDS);
    logic [31:0] mem_q [MEM_WORDS];
    logic [31:0] wword, rword;
    logic        wok;
    assign wword = (waddr - BASE_ADDR) >> 2;
    assign rword = (raddr - BASE_ADDR) >> 2;
    assign wok   = waddr >= BASE_ADDR && wword[31:AW] == '0;
    assign rok   = raddr >= BASE_ADDR && rword[31:AW] == '0;
    assign rdata = rok ? mem_q[rword[AW-1:0]] : '0;
    always_ff @(posedge clock)
        if (we && wok) mem_q[wword[AW-1:0]] <= wdata;
endmodule

// File: rtl/ysyx_23060025_mem_rsp.sv
// ysyx_23060025_mem_rsp: read-only burst responder for the instruction-fetch channel,
// returning registered beats from a preloadable word array after a fixed first-beat latency.
module ysyx_23060025_mem_rsp
    import ysyx_23060025_mem_rsp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          MEM_WORDS = 1024,
    parameter int          LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    input  logic        rready,
    input  logic        init_we,
    input  logic [31:0] init_addr,
    input  logic [31:0] init_wdata
);
    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  beats_q, beats_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  inc_q, inc_d;
    logic        arready_q, arready_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;
    logic [31:0] mem_raddr, mem_rdata, nxt_addr;
    logic [7:0]  len;
    logic        mem_rok, load;

    ysyx_23060025_mem_array #(.BASE_ADDR(BASE_ADDR), .MEM_WORDS(MEM_WORDS)) u_array (
        .clock (clock),
        .we    (init_we),
        .waddr (init_addr),
        .wdata (init_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata),
        .rok   (mem_rok)
    );

    assign len       = arlen == 8'd0 ? 8'd1 : arlen;
    assign nxt_addr  = addr_q + {29'd0, inc_q};
    // The array is addressed with whichever beat could be loaded at the coming edge.
    assign mem_raddr = state_q == S_IDLE ? araddr : state_q == S_DATA ? nxt_addr : addr_q;
    assign arready   = arready_q;
    assign rvalid    = state_q == S_DATA;
    assign rdata     = rdata_q;
    assign rresp     = rresp_q;
    assign rlast     = rlast_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beats_d = beats_q;
        addr_d  = addr_q;
        inc_d   = inc_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        rlast_d = rlast_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: if (arvalid && arready_q) begin
                addr_d  = araddr;
                beats_d = len;
                inc_d   = arsize >= 3'd2 ? 3'd4 : arsize == 3'd1 ? 3'd2 : 3'd1;
                cnt_d   = 4'(LATENCY);
                load    = LATENCY == 0;
                state_d = LATENCY == 0 ? S_DATA : S_WAIT;
            end
            S_WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                load    = cnt_q == 4'd1;
                state_d = load ? S_DATA : S_WAIT;
            end
            S_DATA: if (rready) begin
                state_d = beats_q == 8'd1 ? S_IDLE : S_DATA;
                load    = beats_q != 8'd1;
                addr_d  = load ? nxt_addr : addr_q;
                beats_d = load ? beats_q - 8'd1 : beats_q;
            end
            default: state_d = S_IDLE;
        endcase
        // Beats are captured at load so later preload writes cannot disturb a held beat.
        if (load) begin
            rdata_d = mem_rdata;
            rresp_d = mem_rok ? RESP_OKAY : RESP_DECERR;
            rlast_d = beats_d == 8'd1;
        end
        arready_d = state_d == S_IDLE;
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            beats_q   <= '0;
            addr_q    <= '0;
            inc_q     <= '0;
            arready_q <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            beats_q   <= beats_d;
            addr_q    <= addr_d;
            inc_q     <= inc_d;
            arready_q <= arready_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
endmodule
